veerwolf_rst_ctrl: RTL and testbench
====================================

Name: veerwolf_rst_ctrl

Overview:
Reset sequencer for the VeeRwolf SoC top level. It replaces the simple two-flop reset synchroniser with a sequenced release: it waits for a stable PLL lock, then releases the peripherals, then releases the core. It also re-sequences on PLL lock loss, watchdog or software reset requests, and records the reset cause for the syscon register map.

Parameters:
LOCK_CYCLES, 16, consecutive cycles of synchronised lock required before release (1..65535)
PERIPH_CYCLES, 16, cycles peripherals are held in reset after lock qualifies (1..65535)
CORE_CYCLES, 32, cycles core is held in reset after peripheral release (1..65535)

Ports:
clk  input  1  system clock; all logic in this single domain
rstn  input  1  asynchronous active-low reset; assertion is asynchronous, release takes effect on the next clk edge
i_pll_locked  input  1  PLL lock, asynchronous to clk
i_wdt_rst_req  input  1  watchdog reset request, synchronous to clk, one-cycle pulse or level
i_sw_rst_req  input  1  software reset request from syscon, synchronous to clk
o_rst_periph  output  1  active-high peripheral reset (UART, GPIO, SPI, timers)
o_rst_core  output  1  active-high core reset
o_ready  output  1  high only in RUN
o_rst_cause  output  2  last reset cause: 00 POR, 01 lock loss, 10 watchdog, 11 software
o_rst_count  output  8  saturating count of non-POR resets

Behaviour:
- Internal 2-flop synchroniser on i_pll_locked gives locked_s; both flops reset to 0 by rstn.
- States: WAIT_LOCK, PERIPH, CORE, RUN. Reset state is WAIT_LOCK.
- A single counter cnt (16 bit) is shared by all states and cleared on every state change.
- rstn low (asynchronous, any state): state=WAIT_LOCK, cnt=0, o_rst_periph=1, o_rst_core=1, o_ready=0, o_rst_cause=00, o_rst_count=0.
- All outputs are flop outputs, updated on the same edge as the state transition. Outputs have no combinational decode.
- o_rst_periph=1 in WAIT_LOCK and PERIPH. o_rst_core=1 in all states except RUN. o_ready=1 only in RUN.
- WAIT_LOCK:
  - locked_s=0 clears cnt.
  - locked_s=1 increments cnt.
  - When locked_s=1 and cnt==LOCK_CYCLES-1, go to PERIPH.
- PERIPH:
  - cnt increments each cycle; at cnt==PERIPH_CYCLES-1, go to CORE.
  - locked_s=0 goes to WAIT_LOCK with lock-loss event.
- CORE:
  - cnt increments each cycle; at cnt==CORE_CYCLES-1, go to RUN.
  - locked_s=0 goes to WAIT_LOCK with lock-loss event.
- RUN, evaluated with priority lock loss > watchdog > software:
  - locked_s=0: go to WAIT_LOCK; both resets asserted next cycle; cause=01.
  - i_wdt_rst_req=1: go to PERIPH; both resets asserted; cause=10.
  - i_sw_rst_req=1: go to CORE; only o_rst_core asserted, peripherals keep running; cause=11.
- Request inputs are ignored outside RUN; only lock loss is acted on there. A request held high re-triggers each time RUN is re-entered.
- Every lock-loss, watchdog or software event updates o_rst_cause and increments o_rst_count. o_rst_count saturates at 255.
- o_rst_cause and o_rst_count survive all events except rstn.
- Timing with i_pll_locked high from before rstn release (edge 1 = first clk edge after release):
  - locked_s high after edge 2.
  - PERIPH entered at edge 2+LOCK_CYCLES.
  - o_rst_periph falls at edge 2+LOCK_CYCLES+PERIPH_CYCLES.
  - o_rst_core falls and o_ready rises CORE_CYCLES edges later.
- Software-reset latency: o_rst_core rises on the edge sampling the request, and falls CORE_CYCLES edges later.

Test Plan:
Use LOCK_CYCLES=4, PERIPH_CYCLES=3, CORE_CYCLES=5 for all scenarios.
1. POR, lock high throughout -> o_rst_periph falls at edge 9, o_rst_core falls and o_ready rises at edge 14, cause=00, count=0.
2. Lock glitch low for 1 cycle during WAIT_LOCK (locked_s high 3 cycles, then low, then high) -> cnt restarts, PERIPH entry delayed by the glitch length plus 3 cycles; no output change before qualification.
3. In RUN, 1-cycle i_sw_rst_req -> o_rst_core=1 next edge for exactly 5 cycles, o_rst_periph stays 0, cause=11, count=1.
4. In RUN, i_wdt_rst_req and i_sw_rst_req in the same cycle -> both resets assert, o_rst_periph held 3 cycles then o_rst_core held 5 more, cause=10, count=1.
5. In RUN, i_pll_locked drops (with or without a simultaneous watchdog request) -> both resets assert 3 edges later (2 synchroniser + 1), cause=01. On re-lock, the full 4/3/5 sequence repeats.
6. rstn pulsed low mid-CORE, and separately after 300 software resets -> all outputs return to reset values immediately, count=0. The saturation case shows count=255 before the rstn pulse.

Source files
------------

// File: rtl/veerwolf_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : veerwolf_rst_ctrl
// Purpose  : Sequenced SoC reset: qualify PLL lock, release peripherals, then
//            the core; re-sequence on lock loss, watchdog or software request.
// Revision : 1.0 - initial release
// ============================================================================
module veerwolf_rst_ctrl #(
  parameter int unsigned LOCK_CYCLES   = 16,
  parameter int unsigned PERIPH_CYCLES = 16,
  parameter int unsigned CORE_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_pll_locked,
  input  logic       i_wdt_rst_req,
  input  logic       i_sw_rst_req,
  output logic       o_rst_periph,
  output logic       o_rst_core,
  output logic       o_ready,
  output logic [1:0] o_rst_cause,
  output logic [7:0] o_rst_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PERIPH    = 2'd1,
    CORE      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] c_lock_last   = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] c_periph_last = 16'(PERIPH_CYCLES - 1);
  localparam logic [15:0] c_core_last   = 16'(CORE_CYCLES - 1);

  localparam logic [1:0] c_cause_lock = 2'b01;
  localparam logic [1:0] c_cause_wdt  = 2'b10;
  localparam logic [1:0] c_cause_sw   = 2'b11;

  logic        r_sync1;
  logic        r_locked_s;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_rst_periph;
  logic        r_rst_core;
  logic        r_ready;
  logic [1:0]  r_rst_cause;
  logic [7:0]  r_rst_count;
  logic [7:0]  w_count_inc;

  assign w_count_inc = (r_rst_count == 8'hFF) ? r_rst_count : r_rst_count + 8'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= i_pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Outputs are set on the same edge as the transition into their state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_rst_periph <= 1'b1;
      r_rst_core   <= 1'b1;
      r_ready      <= 1'b0;
      r_rst_cause  <= 2'b00;
      r_rst_count  <= 8'd0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (!r_locked_s) begin
            r_cnt <= '0;
          end else if (r_cnt == c_lock_last) begin
            r_state <= PERIPH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        PERIPH: begin
          if (!r_locked_s) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_rst_cause <= c_cause_lock;
            r_rst_count <= w_count_inc;
          end else if (r_cnt == c_periph_last) begin
            r_state      <= CORE;
            r_cnt        <= '0;
            r_rst_periph <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        CORE: begin
          if (!r_locked_s) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_rst_periph <= 1'b1;
            r_rst_cause  <= c_cause_lock;
            r_rst_count  <= w_count_inc;
          end else if (r_cnt == c_core_last) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_rst_core <= 1'b0;
            r_ready    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        RUN: begin
          // Lock loss outranks watchdog, which outranks software.
          if (!r_locked_s) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_rst_periph <= 1'b1;
            r_rst_core   <= 1'b1;
            r_ready      <= 1'b0;
            r_rst_cause  <= c_cause_lock;
            r_rst_count  <= w_count_inc;
          end else if (i_wdt_rst_req) begin
            r_state      <= PERIPH;
            r_cnt        <= '0;
            r_rst_periph <= 1'b1;
            r_rst_core   <= 1'b1;
            r_ready      <= 1'b0;
            r_rst_cause  <= c_cause_wdt;
            r_rst_count  <= w_count_inc;
          end else if (i_sw_rst_req) begin
            r_state     <= CORE;
            r_cnt       <= '0;
            r_rst_core  <= 1'b1;
            r_ready     <= 1'b0;
            r_rst_cause <= c_cause_sw;
            r_rst_count <= w_count_inc;
          end
        end

        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_rst_periph = r_rst_periph;
  assign o_rst_core   = r_rst_core;
  assign o_ready      = r_ready;
  assign o_rst_cause  = r_rst_cause;
  assign o_rst_count  = r_rst_count;

endmodule
`default_nettype wire

// File: tb/tb_veerwolf_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_veerwolf_rst_ctrl
// Purpose  : Directed bench for the reset sequencer with LOCK=4/PERIPH=3/CORE=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_veerwolf_rst_ctrl;

  logic       clk;
  logic       rstn;
  logic       pll_locked;
  logic       wdt_rst_req;
  logic       sw_rst_req;
  logic       rst_periph;
  logic       rst_core;
  logic       ready;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  int checks = 0;
  int errors = 0;

  veerwolf_rst_ctrl #(
    .LOCK_CYCLES  (4),
    .PERIPH_CYCLES(3),
    .CORE_CYCLES  (5)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_pll_locked (pll_locked),
    .i_wdt_rst_req(wdt_rst_req),
    .i_sw_rst_req (sw_rst_req),
    .o_rst_periph (rst_periph),
    .o_rst_core   (rst_core),
    .o_ready      (ready),
    .o_rst_cause  (rst_cause),
    .o_rst_count  (rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic p, input logic c, input logic r,
                         input logic [1:0] cause, input logic [7:0] cnt);
    chk({tag, ".periph"}, 16'(rst_periph), 16'(p));
    chk({tag, ".core"},   16'(rst_core),   16'(c));
    chk({tag, ".ready"},  16'(ready),      16'(r));
    chk({tag, ".cause"},  16'(rst_cause),  16'(cause));
    chk({tag, ".count"},  16'(rst_count),  16'(cnt));
  endtask

  initial begin
    rstn        = 1'b0;
    pll_locked  = 1'b1;
    wdt_rst_req = 1'b0;
    sw_rst_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("por_reset", 1'b1, 1'b1, 1'b0, 2'b00, 8'd0);

    // POR with lock high: periph falls at edge 9, core/ready at edge 14
    @(negedge clk) rstn = 1'b1;
    step(8);
    chk_out("por_e8", 1'b1, 1'b1, 1'b0, 2'b00, 8'd0);
    step(1);
    chk_out("por_e9", 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);
    step(4);
    chk_out("por_e13", 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);
    step(1);
    chk_out("por_e14", 1'b0, 1'b0, 1'b1, 2'b00, 8'd0);

    // Software reset: core only, 5 cycles
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk_out("sw_e1", 1'b0, 1'b1, 1'b0, 2'b11, 8'd1);
    step(4);
    chk_out("sw_e5", 1'b0, 1'b1, 1'b0, 2'b11, 8'd1);
    step(1);
    chk_out("sw_e6", 1'b0, 1'b0, 1'b1, 2'b11, 8'd1);

    // Watchdog and software together: watchdog wins
    wdt_rst_req = 1'b1;
    sw_rst_req  = 1'b1;
    step(1);
    wdt_rst_req = 1'b0;
    sw_rst_req  = 1'b0;
    chk_out("wdt_e1", 1'b1, 1'b1, 1'b0, 2'b10, 8'd2);
    step(2);
    chk_out("wdt_e3", 1'b1, 1'b1, 1'b0, 2'b10, 8'd2);
    step(1);
    chk_out("wdt_e4", 1'b0, 1'b1, 1'b0, 2'b10, 8'd2);
    step(4);
    chk_out("wdt_e8", 1'b0, 1'b1, 1'b0, 2'b10, 8'd2);
    step(1);
    chk_out("wdt_e9", 1'b0, 1'b0, 1'b1, 2'b10, 8'd2);

    // Lock loss in RUN, watchdog raised as the synchronised loss arrives
    pll_locked = 1'b0;
    step(2);
    chk_out("lol_e2", 1'b0, 1'b0, 1'b1, 2'b10, 8'd2);
    wdt_rst_req = 1'b1;
    step(1);
    wdt_rst_req = 1'b0;
    chk_out("lol_e3", 1'b1, 1'b1, 1'b0, 2'b01, 8'd3);
    pll_locked = 1'b1;
    step(8);
    chk_out("relock_e8", 1'b1, 1'b1, 1'b0, 2'b01, 8'd3);
    step(1);
    chk_out("relock_e9", 1'b0, 1'b1, 1'b0, 2'b01, 8'd3);
    step(4);
    chk_out("relock_e13", 1'b0, 1'b1, 1'b0, 2'b01, 8'd3);
    step(1);
    chk_out("relock_e14", 1'b0, 1'b0, 1'b1, 2'b01, 8'd3);

    // rstn pulsed asynchronously mid-CORE
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk_out("core_pre", 1'b0, 1'b1, 1'b0, 2'b11, 8'd4);
    step(2);
    #2 rstn = 1'b0;
    #1;
    chk_out("async_rst", 1'b1, 1'b1, 1'b0, 2'b00, 8'd0);

    // One-cycle lock glitch while qualifying: PERIPH entry slips by 4
    @(negedge clk) rstn = 1'b1;
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(8);
    chk_out("glitch_e12", 1'b1, 1'b1, 1'b0, 2'b00, 8'd0);
    step(1);
    chk_out("glitch_e13", 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);
    step(4);
    chk_out("glitch_e17", 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);
    step(1);
    chk_out("glitch_e18", 1'b0, 1'b0, 1'b1, 2'b00, 8'd0);

    // 300 software resets saturate the counter at 255
    for (int i = 0; i < 300; i++) begin
      sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      step(5);
    end
    chk_out("sat", 1'b0, 1'b0, 1'b1, 2'b11, 8'd255);
    #2 rstn = 1'b0;
    #1;
    chk_out("sat_rst", 1'b1, 1'b1, 1'b0, 2'b00, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
